fpu_pipe: RTL and testbench
===========================

// Module: fpu_pipe
// PURPOSE
//  Issue/retire pipeline around the combinational fpu (FPU_ADD / FPU_MADD).
//  Registers issued operands, drives them to the fpu, captures fpu res, then
//  retimes it over STAGES-1 result stages toward FP writeback.
//  Valid/ready on both sides, a 32-bit destination-pending mask for hazard
//  checks, and a pipeline flush.
// PARAMETERS
//  STAGES  2  total register stages (>=2): S0 = operand reg, S1..S(STAGES-1) = result regs
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  flush      in   1   kill all in-flight ops
//  in_valid   in   1   upstream op valid
//  in_ready   out  1   pipe accepts op this cycle
//  in_sel     in   2   fpu select (`FPU_ADD, `FPU_MADD from control_sel.vh)
//  in_op1     in   32  rs1 value (IEEE-754 single)
//  in_op2     in   32  rs2 value
//  in_op3     in   32  rs3 value (MADD addend; ignored for ADD)
//  in_rd      in   5   destination FP register
//  fpu_sel    out  2   to fpu.sel  (S0 register)
//  fpu_op1    out  32  to fpu.op1  (S0 register)
//  fpu_op2    out  32  to fpu.op2  (S0 register)
//  fpu_op3    out  32  to fpu.op3  (S0 register)
//  fpu_res    in   32  from fpu.res (combinational from fpu_op*)
//  out_valid  out  1   result valid (last stage)
//  out_ready  in   1   writeback accepts result
//  out_data   out  32  result
//  out_rd     out  5   result destination
//  rd_pending out  32  bit r set while an op targeting f[r] is in flight
//  busy       out  1   any stage valid
// BEHAVIOUR
//  - Reset (async): all stage valids, rd_pending, fpu_sel/op*, out_data, out_rd = 0.
//    Only valids/rd_pending must be reset; others reset too for X-free waveforms.
//  - Per-stage ready: rdy[i] = ~v[i] | rdy[i+1]; rdy[STAGES] = out_ready.
//    Bubbles collapse; a stage advances when its successor can accept.
//  - in_ready = rdy[0] & ~rd_pending[in_rd] & ~flush (WAW stall on a busy rd).
//  - Accept (in_valid & in_ready): S0 <= {sel,op1,op2,op3,rd}; v[0] <= 1.
//  - S0->S1 captures fpu_res (never in_op*); S(i)->S(i+1) copies data/rd.
//  - Latency: accept at edge k -> out_valid high after edge k+STAGES-1 when no
//    backpressure. Full throughput: 1 op/cycle with out_ready held high.
//  - Stalled stage holds data/rd/valid stable; out_data/out_rd stable while
//    out_valid & ~out_ready.
//  - Retire (out_valid & out_ready): clears rd_pending[out_rd].
//  - Same-cycle accept and retire: set-of-in_rd and clear-of-out_rd both apply;
//    in_rd==out_rd impossible (in_ready low while pending).
//  - flush: next edge clears all v[*] and rd_pending; no accept, no retire
//    counted that cycle; flush beats in_valid and out_ready.
//  - rst asserted mid-operation: immediate clear of valids/mask, in-flight ops lost.
//  - busy = |v. No arithmetic done here; rounding/format is entirely fpu's.
// TESTING (STAGES=2, real fpu instance attached)
//  1 FADD op1=3F800000 op2=3F800000 rd=3, out_ready=1 -> out_valid 1 cycle
//    after accept, out_data=40000000, out_rd=3, rd_pending[3] set then cleared.
//  2 FMADD op1=op2=400CCCCD op3=BF570A3D rd=7 -> out_data=40800000, out_rd=7.
//  3 Back-to-back 4 FADDs rd=1..4, out_ready=1 -> in_ready stays 1, results in
//    order on 4 consecutive cycles.
//  4 out_ready=0 for 5 cycles with 3 ops issued -> in_ready drops once S0..S1 full,
//    out_data/out_rd held; release -> all 3 retire in order, none lost/duplicated.
//  5 Issue rd=5, then in_valid with rd=5 next cycle, out_ready=0 -> in_ready=0
//    until rd 5 retires; second op accepted the cycle after retire.
//  6 flush with 2 ops in flight and in_valid=1 -> next cycle busy=0,
//    rd_pending=0, out_valid=0, no op accepted; async rst mid-stream -> same.

Source files
------------

// File: rtl/fpu_pipe.sv
// rtl/fpu_pipe.sv - issue/retire pipeline around the combinational fpu
// S0 holds operands for the fpu; S1..S(STAGES-1) retime the result toward writeback.
module fpu_pipe #(
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_sel,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic [31:0] in_op3,
  input  logic [4:0]  in_rd,
  output logic [1:0]  fpu_sel,
  output logic [31:0] fpu_op1,
  output logic [31:0] fpu_op2,
  output logic [31:0] fpu_op3,
  input  logic [31:0] fpu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic [31:0] rd_pending,
  output logic        busy
);

  logic [STAGES-1:0] v;
  logic [STAGES:0]   rdy;
  logic [4:0]        rd_q  [STAGES];
  logic [31:0]       res_q [1:STAGES-1];
  logic              accept;
  logic              retire;
  logic [31:0]       pend_next;

  // A stage can take new data when empty or when its own content moves on.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] & ~rd_pending[in_rd] & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = v[STAGES-1];
  assign out_data  = res_q[STAGES-1];
  assign out_rd    = rd_q[STAGES-1];
  assign retire    = out_valid & out_ready & ~flush;
  assign busy      = |v;

  // in_rd never equals out_rd on a retire cycle, so set/clear order is irrelevant.
  always_comb begin
    pend_next = rd_pending;
    if (retire) pend_next[out_rd] = 1'b0;
    if (accept) pend_next[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v          <= '0;
      rd_pending <= '0;
      fpu_sel    <= '0;
      fpu_op1    <= '0;
      fpu_op2    <= '0;
      fpu_op3    <= '0;
      for (int i = 0; i < STAGES; i++) rd_q[i] <= '0;
      for (int i = 1; i < STAGES; i++) res_q[i] <= '0;
    end else if (flush) begin
      v          <= '0;
      rd_pending <= '0;
    end else begin
      rd_pending <= pend_next;
      if (rdy[0]) begin
        v[0] <= accept;
        if (accept) begin
          fpu_sel <= in_sel;
          fpu_op1 <= in_op1;
          fpu_op2 <= in_op2;
          fpu_op3 <= in_op3;
          rd_q[0] <= in_rd;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) rd_q[i] <= rd_q[i-1];
        end
      end
      // S1 captures the fpu output; later stages only copy.
      if (rdy[1] && v[0]) res_q[1] <= fpu_res;
      for (int i = 2; i < STAGES; i++) begin
        if (rdy[i] && v[i-1]) res_q[i] <= res_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fpu_pipe.sv
// tb/tb_fpu_pipe.sv - directed self-checking bench for fpu_pipe
// A lookup-table fpu stands in for the real one on the vectors used here.
module tb_fpu_pipe;

  localparam logic [1:0] FPU_ADD  = 2'd0;
  localparam logic [1:0] FPU_MADD = 2'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = FPU_ADD;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [31:0] in_op3 = '0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  fpu_sel;
  logic [31:0] fpu_op1;
  logic [31:0] fpu_op2;
  logic [31:0] fpu_op3;
  logic [31:0] fpu_res;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [31:0] rd_pending;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_pipe #(.STAGES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3), .in_rd(in_rd),
    .fpu_sel(fpu_sel), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_op3(fpu_op3),
    .fpu_res(fpu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .rd_pending(rd_pending), .busy(busy)
  );

  function automatic logic [31:0] fpu_model(input logic [1:0] s, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    if (s == FPU_ADD) begin
      case ({a, b})
        {32'h3F80_0000, 32'h3F80_0000}: r = 32'h4000_0000;
        {32'h3F80_0000, 32'h4000_0000}: r = 32'h4040_0000;
        {32'h4000_0000, 32'h4000_0000}: r = 32'h4080_0000;
        {32'h4000_0000, 32'h4040_0000}: r = 32'h40A0_0000;
        default: r = 32'hFFFF_FFFF;
      endcase
    end else if (s == FPU_MADD && a == 32'h400C_CCCD && b == 32'h400C_CCCD && c == 32'hBF57_0A3D) begin
      r = 32'h4080_0000;
    end
    return r;
  endfunction

  assign fpu_res = fpu_model(fpu_sel, fpu_op1, fpu_op2, fpu_op3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [4:0] rd);
    in_valid = 1'b1;
    in_sel   = s;
    in_op1   = a;
    in_op2   = b;
    in_op3   = c;
    in_rd    = rd;
  endtask

  logic [31:0] a3 [4];
  logic [31:0] b3 [4];
  logic [31:0] r3 [4];

  initial begin
    a3 = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
    b3 = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4040_0000};
    r3 = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};

    // reset state
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pending", rd_pending, 32'd0);
    chk("rst_fpu_op1", fpu_op1, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    #3 rst = 1'b0;
    tick();

    // 1: single FADD
    out_ready = 1'b1;
    drive(FPU_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 5'd3);
    #1 chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t1_pending_set", rd_pending, 32'h0000_0008);
    chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
    chk("t1_fpu_op1", fpu_op1, 32'h3F80_0000);
    tick();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", out_data, 32'h4000_0000);
    chk("t1_out_rd", {27'd0, out_rd}, 32'd3);
    tick();
    chk("t1_drained", {31'd0, out_valid}, 32'd0);
    chk("t1_pending_clr", rd_pending, 32'd0);

    // 2: FMADD
    drive(FPU_MADD, 32'h400C_CCCD, 32'h400C_CCCD, 32'hBF57_0A3D, 5'd7);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_out_data", out_data, 32'h4080_0000);
    chk("t2_out_rd", {27'd0, out_rd}, 32'd7);
    tick();

    // 3: four back-to-back FADDs
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(FPU_ADD, a3[i], b3[i], 32'd0, 5'(i + 1));
      else in_valid = 1'b0;
      #1;
      if (i < 4) chk($sformatf("t3_in_ready%0d", i), {31'd0, in_ready}, 32'd1);
      if (i >= 2) begin
        chk($sformatf("t3_valid%0d", i - 2), {31'd0, out_valid}, 32'd1);
        chk($sformatf("t3_data%0d", i - 2), out_data, r3[i-2]);
        chk($sformatf("t3_rd%0d", i - 2), {27'd0, out_rd}, 32'(i - 1));
      end
      tick();
    end
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_pending", rd_pending, 32'd0);

    // 4: backpressure with three ops
    out_ready = 1'b0;
    drive(FPU_ADD, a3[0], b3[0], 32'd0, 5'd8);
    tick();
    drive(FPU_ADD, a3[1], b3[1], 32'd0, 5'd9);
    #1 chk("t4_in_ready_b", {31'd0, in_ready}, 32'd1);
    tick();
    drive(FPU_ADD, a3[2], b3[2], 32'd0, 5'd10);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_hold_data", out_data, 32'h4000_0000);
      chk("t4_hold_rd", {27'd0, out_rd}, 32'd8);
      tick();
    end
    chk("t4_pending_full", rd_pending, 32'h0000_0300);
    out_ready = 1'b1;
    #1 chk("t4_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_second_data", out_data, 32'h4040_0000);
    chk("t4_second_rd", {27'd0, out_rd}, 32'd9);
    tick();
    chk("t4_third_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_third_data", out_data, 32'h4080_0000);
    chk("t4_third_rd", {27'd0, out_rd}, 32'd10);
    tick();
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_pending", rd_pending, 32'd0);

    // 5: WAW stall on rd 5
    out_ready = 1'b0;
    drive(FPU_ADD, a3[0], b3[0], 32'd0, 5'd5);
    tick();
    drive(FPU_ADD, a3[3], b3[3], 32'd0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_waw_stall", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("t5_head_rd", {27'd0, out_rd}, 32'd5);
    out_ready = 1'b1;
    #1 chk("t5_still_pending", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t5_after_retire_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_after_retire_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t5_pending_again", rd_pending, 32'h0000_0020);
    tick();
    chk("t5_out_data", out_data, 32'h40A0_0000);
    chk("t5_out_rd", {27'd0, out_rd}, 32'd5);
    tick();
    chk("t5_pending_clr", rd_pending, 32'd0);

    // 6: flush with two ops in flight and a pending issue
    out_ready = 1'b0;
    drive(FPU_ADD, a3[0], b3[0], 32'd0, 5'd11);
    tick();
    drive(FPU_ADD, a3[1], b3[1], 32'd0, 5'd12);
    tick();
    chk("t6_pending_pre", rd_pending, 32'h0000_1800);
    drive(FPU_ADD, a3[2], b3[2], 32'd0, 5'd13);
    out_ready = 1'b1;
    flush = 1'b1;
    #1 chk("t6_flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t6_flush_busy", {31'd0, busy}, 32'd0);
    chk("t6_flush_pending", rd_pending, 32'd0);
    chk("t6_flush_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t6_no_accept", {31'd0, busy}, 32'd0);

    // async reset mid-stream
    out_ready = 1'b0;
    drive(FPU_ADD, a3[0], b3[0], 32'd0, 5'd14);
    tick();
    drive(FPU_ADD, a3[1], b3[1], 32'd0, 5'd15);
    tick();
    in_valid = 1'b0;
    chk("t6_pre_rst_pending", rd_pending, 32'h0000_C000);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_pending", rd_pending, 32'd0);
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_out_rd", {27'd0, out_rd}, 32'd0);
    #2 rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
